// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_pkg;

    localparam int ADDR_W    = 2;
    localparam int NUM_PORTS = 3;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

endpackage

// File: rtl/router_port_sel.sv
// Combinational 3:1 selector picking the empty flag and soft reset of the addressed FIFO.
module router_port_sel
    import router_pkg::*;
(
    input  logic [ADDR_W-1:0]    empty_addr,
    input  logic [ADDR_W-1:0]    sr_addr,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    output logic                 empty_sel,
    output logic                 sr_sel
);

    // Address 3 never names a FIFO, so it selects an inactive flag.
    always_comb begin
        empty_sel = 1'b0;
        case (empty_addr)
            2'd0:    empty_sel = fifo_empty[0];
            2'd1:    empty_sel = fifo_empty[1];
            2'd2:    empty_sel = fifo_empty[2];
            default: empty_sel = 1'b0;
        endcase
    end

    always_comb begin
        sr_sel = 1'b0;
        case (sr_addr)
            2'd0:    sr_sel = soft_reset[0];
            2'd1:    sr_sel = soft_reset[1];
            2'd2:    sr_sel = soft_reset[2];
            default: sr_sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/router_fsm.sv
// Packet-sequencing FSM for the 1x3 router: decodes headers and drives the
// register block and FIFO write path through header, payload, parity and full handling.
module router_fsm
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              full_state,
    output logic              laf_state,
    output logic              rst_int_reg,
    output logic              write_enb_reg,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   empty_addr;
    logic                empty_sel;
    logic                sr_sel;
    logic                addr_ok;

    // The header is still on data_in while decoding, so look at it directly there.
    assign empty_addr = (state_q == DECODE_ADDRESS) ? data_in : addr_q;
    assign addr_ok    = (data_in != ADDR_INVALID);

    router_port_sel u_port_sel (
        .empty_addr (empty_addr),
        .sr_addr    (addr_q),
        .fifo_empty ({fifo_empty_2, fifo_empty_1, fifo_empty_0}),
        .soft_reset ({soft_reset_2, soft_reset_1, soft_reset_0}),
        .empty_sel  (empty_sel),
        .sr_sel     (sr_sel)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;

        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid && addr_ok) begin
                    addr_d  = data_in;
                    state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            WAIT_TILL_EMPTY: begin
                if (empty_sel) state_d = LOAD_FIRST_DATA;
            end
            default: state_d = DECODE_ADDRESS;
        endcase

        // A timeout on the addressed FIFO abandons the packet from any state.
        if (state_q != DECODE_ADDRESS && sr_sel)
            state_d = DECODE_ADDRESS;
    end

    always_comb begin
        detect_add    = (state_q == DECODE_ADDRESS);
        lfd_state     = (state_q == LOAD_FIRST_DATA);
        ld_state      = (state_q == LOAD_DATA);
        full_state    = (state_q == FIFO_FULL_STATE);
        laf_state     = (state_q == LOAD_AFTER_FULL);
        rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
        write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                     || (state_q == LOAD_AFTER_FULL);
        busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
    end

endmodule
